// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EXE stage.
// MULT/MULTU use a shift-add loop over a 2*DATA_W accumulator, and DIV/DIVU use a
// restoring shift-subtract loop. Both loops work on unsigned magnitudes. Signs are
// applied in a single FIX cycle, and DONE commits the result to HI/LO.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;   // product high half / partial remainder
    logic [DATA_W-1:0] acc_lo_q, acc_lo_d;   // multiplier -> product low / dividend -> quotient
    logic [DATA_W-1:0] opb_q, opb_d;         // |multiplicand| or |divisor|
    logic              is_div_q, is_div_d;
    logic              is_signed_q, is_signed_d;
    logic              neg_res_q, neg_res_d; // operand signs differ
    logic              neg_rem_q, neg_rem_d; // dividend was negative
    logic              dbz_pend_q, dbz_pend_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Operand magnitudes for the signed ops (op[0]=0 means signed)
    logic              signed_op, a_neg, b_neg;
    logic [DATA_W-1:0] abs_a, abs_b;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & operand_a[DATA_W-1];
    assign b_neg     = signed_op & operand_b[DATA_W-1];
    assign abs_a     = a_neg ? -operand_a : operand_a;
    assign abs_b     = b_neg ? -operand_b : operand_b;

    // One shift-add step: add the multiplicand when the multiplier LSB is set, then shift right
    logic [DATA_W:0]   mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});

    // One restoring step: shift the next dividend bit into the remainder and subtract if it fits
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem;
    assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_rem   = div_shift[DATA_W-1:0] - opb_q;

    logic [2*DATA_W-1:0] neg_prod;
    assign neg_prod = -{acc_hi_q, acc_lo_q};

    // Next-state logic for the FSM, the datapath and the result registers
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opb_d       = opb_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        dbz_pend_d  = dbz_pend_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    is_div_d    = op[1];
                    is_signed_d = signed_op;
                    neg_res_d   = a_neg ^ b_neg;
                    neg_rem_d   = a_neg;
                    dbz_pend_d  = op[1] && (operand_b == '0);
                    dbz_d       = 1'b0;
                    cnt_d       = CNT_W'(DATA_W);
                    acc_hi_d    = '0;
                    if (op[1]) begin
                        // Divide by zero keeps the raw dividend so it can be reported in HI
                        acc_lo_d = (operand_b == '0) ? operand_a : abs_a;
                        opb_d    = abs_b;
                        state_d  = (operand_b == '0) ? S_FIX : S_RUN;
                    end else begin
                        acc_lo_d = abs_b;
                        opb_d    = abs_a;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_ge ? div_rem : div_shift[DATA_W-1:0];
                        acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[DATA_W:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (dbz_pend_q) begin
                        acc_hi_d = acc_lo_q;
                        acc_lo_d = '1;
                    end else if (is_signed_q) begin
                        if (!is_div_q) begin
                            if (neg_res_q) begin
                                {acc_hi_d, acc_lo_d} = neg_prod;
                            end
                        end else begin
                            // MIN / -1 naturally wraps back to MIN with a zero remainder
                            if (neg_res_q) acc_lo_d = -acc_lo_q;
                            if (neg_rem_q) acc_hi_d = -acc_hi_q;
                        end
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                // DONE: commit regardless of abort
                hi_d    = acc_hi_q;
                lo_d    = acc_lo_q;
                dbz_d   = dbz_pend_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers: synchronous active-low reset, frozen while enable is low
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_pend_q  <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else if (enable) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opb_q       <= opb_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            dbz_pend_q  <= dbz_pend_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that extends the EXE stage of the 5-stage pipelined CPU with MULT/MULTU/DIV/DIVU and HI/LO result registers.
- Generalised in operand width.
- Runs multi-cycle beside the single-cycle ALU and drives a stall toward pipeline control while busy.
- The abort input lets a branch/jump resolved in MEM kill a speculative operation.

Parameters:
- DATA_W, 32, operand and HI/LO width; any even value >= 4.
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk  input  1  main clock
- arst_n  input  1  reset; synchronous, active-low
- enable  input  1  global run enable; low freezes all state
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- operand_a  input  DATA_W  multiplicand / dividend (rs)
- operand_b  input  DATA_W  multiplier / divisor (rt)
- abort  input  1  kill in-flight operation
- busy  output  1  operation in flight; used as pipeline stall
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  sticky flag for last completed op; cleared on next accepted start
- hi  output  DATA_W  product upper half / remainder
- lo  output  DATA_W  product lower half / quotient

Behaviour:
- Reset: on a clk edge with arst_n=0:
  - state=IDLE
  - busy=0, done=0, div_by_zero=0
  - hi=0, lo=0
  - counter=0
- enable=0: no state, counter, register or output change, including done; latency stretches by the number of disabled cycles.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, start=1, abort=0:
  - Latch sign info.
  - Load |a| and |b| for signed ops, raw values for unsigned ops.
  - Counter=DATA_W.
  - Next state RUN; busy=1 from the next cycle.
- RUN: one iteration per cycle.
  - Multiply: shift-add over a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements; at 1 go to FIX.
- FIX, one cycle:
  - Signed multiply: negate the 2*DATA_W product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- DONE, one cycle:
  - hi/lo updated, done=1, busy=0.
  - Next state IDLE.
- Latency: done asserts DATA_W+2 enabled edges after the start-sampling edge (34 for DATA_W=32). Start is accepted again in the cycle after DONE.
- Divide by zero, detected at start:
  - Skip RUN and go to FIX then DONE; done asserts 2 edges after start.
  - lo = all ones, hi = operand_a, div_by_zero=1.
- Signed overflow (MIN / -1): lo=MIN, hi=0; no flag.
- hi/lo hold their value until the next DONE; only DONE writes them.
- start while busy: ignored, no queueing.
- abort in RUN or FIX: IDLE on the next edge, busy=0, no done, hi/lo/div_by_zero unchanged.
- abort in DONE: ignored; the result commits.
- abort and start in the same IDLE cycle: abort wins, start is dropped.
- Reset mid-operation: immediate return to reset values; no done.
- Multiply uses the full 2*DATA_W product and never overflows.
- All arithmetic is unsigned internally; signs are applied only in FIX.

Test Plan:
All scenarios use DATA_W=32 and enable=1 unless stated.
- MULT a=FFFFFFFD (-3), b=00000007 -> done at edge 34, hi=FFFFFFFF, lo=FFFFFFEB; busy high for edges 1..33.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. Then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- DIVU a=00000064, b=0 -> done at edge 2, lo=FFFFFFFF, hi=00000064, div_by_zero=1. Then DIVU 100/7 -> lo=0000000E, hi=00000002, div_by_zero=0.
- MULTU 5*6 with abort at edge 10 -> no done, hi/lo keep the previous values. A start on the same edge as abort is dropped. A fresh start afterwards gives lo=0000001E at +34.
- enable low for 5 cycles mid-RUN -> done at edge 39. arst_n low at edge 20 of a DIV -> all outputs 0 and no done.
